// File: rtl/mdu_hilo_if.sv
// Pipeline-to-MDU bundle: op fields and operands in, stall/read data out.
interface mdu_hilo_if #(
  parameter int WIDTH = 32
);
  logic             valid_in;
  logic             flush;
  logic [1:0]       MULT;
  logic [1:0]       DIV;
  logic [1:0]       MFHL;
  logic [1:0]       MTHL;
  logic [WIDTH-1:0] rs_value;
  logic [WIDTH-1:0] rt_value;
  logic             busy;
  logic [WIDTH-1:0] hilo_rdata;
  logic             done;

  modport master (
    output valid_in, flush, MULT, DIV,
    output MFHL, MTHL, rs_value, rt_value,
    input  busy, hilo_rdata, done
  );

  modport slave (
    input  valid_in, flush, MULT, DIV,
    input  MFHL, MTHL, rs_value, rt_value,
    output busy, hilo_rdata, done
  );
endinterface

// File: rtl/mdu_hilo.sv
// EX-stage multiply/divide unit with HI/LO; iterative shift-add and restoring divide.
// MDU_FAST_MUL_EN: single-cycle combinational multiply instead of iterative.
module mdu_hilo #(
  parameter int WIDTH = 32
) (
  input logic        clk,
  input logic        resetn,
  mdu_hilo_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    MUL_RUN,
    DIV_RUN
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [WIDTH-1:0] a_q, b_q, raw_q;
  logic [WIDTH-1:0] rem_q, quo_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [CW-1:0]    cnt_q;
  logic             neg_q, sa_q, dz_q;
  logic             done_q;

  logic             is_mul, is_div, sgn, start;
  logic [WIDTH-1:0] mag_rs, mag_rt;
  logic [WIDTH:0]   msum;
  logic [2*WIDTH-1:0] prod_d, mul_res, mul_fin;
  logic             mul_last;
  logic [WIDTH:0]   dt, dsub;
  logic             dge;
  logic [WIDTH-1:0] rem_d, quo_d, q_fin, r_fin;

  assign is_mul = |bus.MULT;
  assign is_div = |bus.DIV;
  // signed variant wins within a field, DIV wins across fields
  assign sgn    = is_div ? bus.DIV[0] : bus.MULT[0];
  assign start  = bus.valid_in & ~bus.flush
                & (state_q == IDLE) & (is_mul | is_div);

  assign mag_rs = (sgn & bus.rs_value[WIDTH-1])
                ? -bus.rs_value : bus.rs_value;
  assign mag_rt = (sgn & bus.rt_value[WIDTH-1])
                ? -bus.rt_value : bus.rt_value;

  assign msum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                + {1'b0, (prod_q[0] ? a_q : '0)};
  assign prod_d = {msum, prod_q[WIDTH-1:1]};

`ifdef MDU_FAST_MUL_EN
  assign mul_res  = {{WIDTH{1'b0}}, a_q}
                  * {{WIDTH{1'b0}}, b_q};
  assign mul_last = 1'b1;
`else
  assign mul_res  = prod_d;
  assign mul_last = (cnt_q == CW'(1));
`endif

  assign mul_fin = neg_q ? -mul_res : mul_res;

  // remainder stays below divisor, so W bits hold it after the subtract
  assign dt    = {rem_q, quo_q[WIDTH-1]};
  assign dge   = (dt >= {1'b0, b_q});
  assign dsub  = dt - {1'b0, b_q};
  assign rem_d = dge ? dsub[WIDTH-1:0] : dt[WIDTH-1:0];
  assign quo_d = {quo_q[WIDTH-2:0], dge};
  assign q_fin = dz_q ? '1 : (neg_q ? -quo_d : quo_d);
  assign r_fin = dz_q ? raw_q : (sa_q ? -rem_d : rem_d);

  assign bus.busy = start | (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.hilo_rdata = bus.MFHL[1] ? hi_q
                        : (bus.MFHL[0] ? lo_q : '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      raw_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      sa_q    <= 1'b0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.valid_in & ~bus.flush & ~bus.busy) begin
        if (bus.MTHL[1]) hi_q <= bus.rs_value;
        if (bus.MTHL[0]) lo_q <= bus.rs_value;
      end
      if (bus.flush) begin
        state_q <= IDLE;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (start) begin
              a_q    <= mag_rs;
              b_q    <= mag_rt;
              raw_q  <= bus.rs_value;
              prod_q <= {{WIDTH{1'b0}}, mag_rt};
              rem_q  <= '0;
              quo_q  <= mag_rs;
              cnt_q  <= CW'(WIDTH);
              neg_q  <= sgn & (bus.rs_value[WIDTH-1]
                             ^ bus.rt_value[WIDTH-1]);
              sa_q   <= sgn & bus.rs_value[WIDTH-1];
              dz_q   <= is_div & (bus.rt_value == '0);
              state_q <= is_div ? DIV_RUN : MUL_RUN;
            end
          end
          MUL_RUN: begin
            prod_q <= prod_d;
            cnt_q  <= cnt_q - CW'(1);
            if (mul_last) begin
              hi_q    <= mul_fin[2*WIDTH-1:WIDTH];
              lo_q    <= mul_fin[WIDTH-1:0];
              done_q  <= 1'b1;
              state_q <= IDLE;
            end
          end
          DIV_RUN: begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
              hi_q    <= r_fin;
              lo_q    <= q_fin;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mdu_hilo.sv
// Scoreboard bench for mdu_hilo: mul/div results, latency, flush, reset, mthi/mtlo.
module tb_mdu_hilo;
  logic clk;
  logic resetn;

  mdu_hilo_if #(.WIDTH(32)) bus ();

  mdu_hilo #(.WIDTH(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

`ifdef MDU_FAST_MUL_EN
  localparam int MUL_BUSY = 2;
`else
  localparam int MUL_BUSY = 33;
`endif
  localparam int DIV_BUSY = 33;

  task automatic idle_inputs();
    bus.valid_in = 1'b0;
    bus.flush    = 1'b0;
    bus.MULT     = 2'b00;
    bus.DIV      = 2'b00;
    bus.MFHL     = 2'b00;
    bus.MTHL     = 2'b00;
    bus.rs_value = '0;
    bus.rt_value = '0;
  endtask

  task automatic run_op(input string nm, input logic [1:0] mul,
                        input logic [1:0] dv,
                        input logic [31:0] rs, input logic [31:0] rt,
                        input logic [31:0] eh, input logic [31:0] el,
                        input int ebusy);
    exp_t e;
    int   nb;
    int   nd;
    bit   fin;
    nb  = 0;
    nd  = 0;
    fin = 1'b0;
    @(negedge clk);
    bus.valid_in = 1'b1;
    bus.MULT     = mul;
    bus.DIV      = dv;
    bus.rs_value = rs;
    bus.rt_value = rt;
    e.hi = eh;
    e.lo = el;
    sb.push_back(e);
    for (int i = 0; i < 100; i++) begin
      #1;
      if (!bus.busy) begin
        fin = 1'b1;
        break;
      end
      nb++;
      @(posedge clk);
      #1;
      idle_inputs();
      if (bus.done) begin
        nd++;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          bus.MFHL = 2'b10;
          #1;
          n_cmp++;
          if (bus.hilo_rdata !== e.hi) begin
            n_err++;
            $display("FAIL %s hi: got %h want %h",
                     nm, bus.hilo_rdata, e.hi);
          end
          bus.MFHL = 2'b01;
          #1;
          n_cmp++;
          if (bus.hilo_rdata !== e.lo) begin
            n_err++;
            $display("FAIL %s lo: got %h want %h",
                     nm, bus.hilo_rdata, e.lo);
          end
          bus.MFHL = 2'b00;
        end
      end
      @(negedge clk);
    end
    n_cmp++;
    if (!fin) begin
      n_err++;
      $display("FAIL %s timeout: busy never dropped", nm);
    end
    n_cmp++;
    if (nb !== ebusy) begin
      n_err++;
      $display("FAIL %s busy_cycles: got %0d want %0d", nm, nb, ebusy);
    end
    n_cmp++;
    if (nd !== 1) begin
      n_err++;
      $display("FAIL %s done_pulses: got %0d want 1", nm, nd);
    end
  endtask

  task automatic read_hl(output logic [31:0] h, output logic [31:0] l);
    bus.MFHL = 2'b10;
    #1;
    h = bus.hilo_rdata;
    bus.MFHL = 2'b01;
    #1;
    l = bus.hilo_rdata;
    bus.MFHL = 2'b00;
  endtask

  task automatic mt_write(input logic [1:0] which, input logic [31:0] v);
    @(negedge clk);
    bus.valid_in = 1'b1;
    bus.MTHL     = which;
    bus.rs_value = v;
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic test_reset();
    logic [31:0] h, l;
    idle_inputs();
    resetn = 1'b0;
    #2;
    read_hl(h, l);
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL reset busy/done: got %b/%b want 0/0",
               bus.busy, bus.done);
    end
    n_cmp++;
    if (h !== 32'h0 || l !== 32'h0) begin
      n_err++;
      $display("FAIL reset hilo: got %h/%h want 0/0", h, l);
    end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_mul();
    run_op("mult_neg", 2'b01, 2'b00, 32'hFFFFFFFD, 32'd7,
           32'hFFFFFFFF, 32'hFFFFFFEB, MUL_BUSY);
    run_op("multu_max", 2'b10, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF,
           32'hFFFFFFFE, 32'h00000001, MUL_BUSY);
    run_op("mult_pos", 2'b01, 2'b00, 32'h12345678, 32'd9,
           32'h00000000, 32'hA3D70A38, MUL_BUSY);
    run_op("mult_minmin", 2'b11, 2'b00, 32'h80000000, 32'h80000000,
           32'h40000000, 32'h00000000, MUL_BUSY);
  endtask

  task automatic test_div();
    run_op("div_neg", 2'b00, 2'b01, 32'hFFFFFFF9, 32'd2,
           32'hFFFFFFFF, 32'hFFFFFFFD, DIV_BUSY);
    run_op("divu", 2'b00, 2'b10, 32'hFFFFFFF9, 32'd2,
           32'h00000001, 32'h7FFFFFFC, DIV_BUSY);
    run_op("divu_zero", 2'b00, 2'b10, 32'd7, 32'd0,
           32'h00000007, 32'hFFFFFFFF, DIV_BUSY);
    run_op("div_zero", 2'b00, 2'b01, 32'hFFFFFFFB, 32'd0,
           32'hFFFFFFFB, 32'hFFFFFFFF, DIV_BUSY);
    run_op("div_ovf", 2'b00, 2'b01, 32'h80000000, 32'hFFFFFFFF,
           32'h00000000, 32'h80000000, DIV_BUSY);
    run_op("div_wins", 2'b01, 2'b11, 32'd100, 32'd3,
           32'h00000001, 32'h00000021, DIV_BUSY);
  endtask

  task automatic test_back_to_back();
    run_op("b2b_mult", 2'b01, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF,
           32'h00000000, 32'h00000001, MUL_BUSY);
    run_op("b2b_divu", 2'b00, 2'b10, 32'd1000, 32'd7,
           32'h00000006, 32'h0000008E, DIV_BUSY);
  endtask

  task automatic test_mtlo();
    logic [31:0] h, l;
    mt_write(2'b01, 32'hDEADBEEF);
    read_hl(h, l);
    n_cmp++;
    if (l !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL mtlo: got %h want deadbeef", l);
    end
    n_cmp++;
    if (bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL mtlo_done: got %b want 0", bus.done);
    end
  endtask

  task automatic test_flush_reset();
    logic [31:0] h, l;
    int nd;
    nd = 0;
    mt_write(2'b10, 32'h11111111);
    mt_write(2'b01, 32'h22222222);
    @(negedge clk);
    bus.valid_in = 1'b1;
    bus.DIV      = 2'b01;
    bus.rs_value = 32'd100;
    bus.rt_value = 32'd3;
    for (int c = 1; c < 10; c++) begin
      @(posedge clk);
      #1;
      idle_inputs();
      if (bus.done) nd++;
      @(negedge clk);
    end
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    if (bus.done) nd++;
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL flush_busy: got %b want 0", bus.busy);
    end
    read_hl(h, l);
    n_cmp++;
    if (h !== 32'h11111111 || l !== 32'h22222222) begin
      n_err++;
      $display("FAIL flush_hilo: got %h/%h want 11111111/22222222",
               h, l);
    end
    @(posedge clk);
    #1;
    if (bus.done) nd++;
    n_cmp++;
    if (nd !== 0) begin
      n_err++;
      $display("FAIL flush_done: got %0d pulses want 0", nd);
    end
    @(negedge clk);
    bus.valid_in = 1'b1;
    bus.MULT     = 2'b10;
    bus.rs_value = 32'hFFFFFFFF;
    bus.rt_value = 32'd5;
    @(posedge clk);
    #1;
    idle_inputs();
    repeat (4) @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    read_hl(h, l);
    n_cmp++;
    if (bus.busy !== 1'b0 || h !== 32'h0 || l !== 32'h0) begin
      n_err++;
      $display("FAIL rst_mid: busy %b hi %h lo %h want 0/0/0",
               bus.busy, h, l);
    end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_mtlo_busy();
    logic [31:0] h, l;
    bit fin;
    fin = 1'b0;
    @(negedge clk);
    bus.valid_in = 1'b1;
    bus.DIV      = 2'b10;
    bus.rs_value = 32'd100;
    bus.rt_value = 32'd3;
    @(posedge clk);
    #1;
    bus.DIV      = 2'b00;
    bus.MTHL     = 2'b01;
    bus.rs_value = 32'hCAFEF00D;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (!bus.busy) begin
        fin = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!fin) begin
      n_err++;
      $display("FAIL mtlo_busy timeout: busy never dropped");
    end
    read_hl(h, l);
    n_cmp++;
    if (l !== 32'h00000021 || h !== 32'h00000001) begin
      n_err++;
      $display("FAIL mtlo_held: got %h/%h want 00000001/00000021",
               h, l);
    end
    @(posedge clk);
    #1;
    idle_inputs();
    read_hl(h, l);
    n_cmp++;
    if (l !== 32'hCAFEF00D) begin
      n_err++;
      $display("FAIL mtlo_after: got %h want cafef00d", l);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_back_to_back();
    test_mtlo();
    test_flush_reset();
    test_mtlo_busy();
    n_cmp++;
    if (sb.size() !== 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d left want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
